// File: rtl/uart_reg_writer.sv
// UART-framed register-bus master: SYNC, ADDR, DATA[, CHK] bytes become one data/addr/en write.
// Build option: define CHECKSUM_EN for the 4-byte frame with CHK == ADDR ^ DATA ^ SYNC_BYTE.
module uart_reg_writer #(
    parameter int          CLK_MHZ      = 100,
    parameter int          BAUD         = 115_200,
    parameter int          PAR_MAX_VAL  = 255,
    parameter int          ADDR_MAX     = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 40,
    localparam int         DW           = $clog2(PAR_MAX_VAL + 1),
    localparam int         AW           = $clog2(ADDR_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          en,
    output logic          err
);
    localparam int DIV    = CLK_MHZ * 1_000_000 / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int CW     = $clog2(DIV + 1);
    localparam int TO_LIM = TIMEOUT_BITS * DIV;
    localparam int TW     = $clog2(TO_LIM + 1);
    localparam logic [7:0] ADDR_LIM = 8'(ADDR_MAX);
    localparam logic [7:0] DATA_LIM = 8'(PAR_MAX_VAL);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;
    typedef enum logic [2:0] {
        F_IDLE,
        F_ADDR,
        F_DATA,
`ifdef CHECKSUM_EN
        F_CHK,
`endif
        F_EMIT
    } fr_state_e;

    // Range check is made on the full byte, before any truncation to DW/AW.
    function automatic logic in_range(input logic [7:0] a, input logic [7:0] d);
        return (a <= ADDR_LIM) && (d <= DATA_LIM);
    endfunction

`ifdef CHECKSUM_EN
    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] d);
        return a ^ d ^ SYNC_BYTE;
    endfunction
    logic [7:0]    dbuf_q, dbuf_d;
`endif

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     rs_q, rs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_vld_q, byte_vld_d, frm_err_q, frm_err_d;
    fr_state_e     fs_q, fs_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    abuf_q, abuf_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          en_q, en_d, err_q, err_d;
    logic          start_det_s, in_frame_s, timeout_s;

    assign start_det_s = (rs_q == R_IDLE) && rx_prev_q && !rx_sync_q;
    assign in_frame_s  = (fs_q == F_ADDR) || (fs_q == F_DATA)
`ifdef CHECKSUM_EN
                         || (fs_q == F_CHK)
`endif
                         ;
    assign timeout_s   = in_frame_s && (to_cnt_q == TW'(TO_LIM));

    // Bit receiver: mid-start glitch filter, centre sampling, stop-bit framing check.
    always_comb begin
        rs_d       = rs_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        frm_err_d  = 1'b0;
        case (rs_q)
            R_IDLE: begin
                if (start_det_s) begin
                    cnt_d = CW'(HALF - 1);
                    rs_d  = R_START;
                end else begin
                    rs_d = R_IDLE;
                end
            end
            R_START: begin
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_sync_q) begin
                    rs_d = R_IDLE;
                end else begin
                    cnt_d     = CW'(DIV - 1);
                    bit_idx_d = 3'd0;
                    rs_d      = R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = CW'(DIV - 1);
                    if (bit_idx_q == 3'd7) begin
                        rs_d = R_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            R_STOP: begin
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_sync_q) begin
                    byte_vld_d = 1'b1;
                    rs_d       = R_IDLE;
                end else begin
                    frm_err_d = 1'b1;
                    rs_d      = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rx_sync_q) begin
                    rs_d = R_IDLE;
                end else begin
                    rs_d = R_WAIT;
                end
            end
            default: rs_d = R_IDLE;
        endcase
    end

    // Frame FSM, inter-byte timeout and the registered write/err outputs.
    always_comb begin
        fs_d   = fs_q;
        abuf_d = abuf_q;
`ifdef CHECKSUM_EN
        dbuf_d = dbuf_q;
`endif
        addr_d = addr_q;
        data_d = data_q;
        en_d   = 1'b0;
        err_d  = 1'b0;
        if (start_det_s || !in_frame_s) begin
            to_cnt_d = {TW{1'b0}};
        end else if (!timeout_s) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (frm_err_q || timeout_s) begin
            err_d = 1'b1;
            fs_d  = F_IDLE;
        end else if (fs_q == F_EMIT) begin
            fs_d = F_IDLE;
        end else if (byte_vld_q) begin
            case (fs_q)
                F_IDLE: begin
                    if (shift_q == SYNC_BYTE) begin
                        fs_d = F_ADDR;
                    end else begin
                        fs_d = F_IDLE;
                    end
                end
                F_ADDR: begin
                    abuf_d = shift_q;
                    fs_d   = F_DATA;
                end
`ifdef CHECKSUM_EN
                F_DATA: begin
                    dbuf_d = shift_q;
                    fs_d   = F_CHK;
                end
                F_CHK: begin
                    if ((shift_q == frame_sum(abuf_q, dbuf_q)) && in_range(abuf_q, dbuf_q)) begin
                        addr_d = abuf_q[AW-1:0];
                        data_d = dbuf_q[DW-1:0];
                        en_d   = 1'b1;
                        fs_d   = F_EMIT;
                    end else begin
                        err_d = 1'b1;
                        fs_d  = F_IDLE;
                    end
                end
`else
                F_DATA: begin
                    if (in_range(abuf_q, shift_q)) begin
                        addr_d = abuf_q[AW-1:0];
                        data_d = shift_q[DW-1:0];
                        en_d   = 1'b1;
                        fs_d   = F_EMIT;
                    end else begin
                        err_d = 1'b1;
                        fs_d  = F_IDLE;
                    end
                end
`endif
                default: fs_d = F_IDLE;
            endcase
        end else begin
            fs_d = fs_q;
        end
    end

    // All state; rx enters through a 2-FF synchronizer plus an edge-detect flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rs_q       <= R_IDLE;
            cnt_q      <= {CW{1'b0}};
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            fs_q       <= F_IDLE;
            to_cnt_q   <= {TW{1'b0}};
            abuf_q     <= 8'd0;
`ifdef CHECKSUM_EN
            dbuf_q     <= 8'd0;
`endif
            addr_q     <= {AW{1'b0}};
            data_q     <= {DW{1'b0}};
            en_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rs_q       <= rs_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_vld_q <= byte_vld_d;
            frm_err_q  <= frm_err_d;
            fs_q       <= fs_d;
            to_cnt_q   <= to_cnt_d;
            abuf_q     <= abuf_d;
`ifdef CHECKSUM_EN
            dbuf_q     <= dbuf_d;
`endif
            addr_q     <= addr_d;
            data_q     <= data_d;
            en_q       <= en_d;
            err_q      <= err_d;
        end
    end

    assign data = data_q;
    assign addr = addr_q;
    assign en   = en_q;
    assign err  = err_q;
endmodule

// File: tb/tb_uart_reg_writer.sv
// Scoreboard bench for uart_reg_writer at DIV=100; frames follow the CHECKSUM_EN build option.
module tb_uart_reg_writer;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic [2:0] addr;
    logic       en;
    logic       err;

    always #5 clk = ~clk;

    uart_reg_writer #(
        .CLK_MHZ(100), .BAUD(1_000_000), .PAR_MAX_VAL(255),
        .ADDR_MAX(4), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(40)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .addr(addr), .en(en), .err(err)
    );

    typedef struct {
        bit         is_wr;
        logic [2:0] a;
        logic [7:0] d;
        int         lo;
        int         hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_start = 0;
    logic en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_win(input string name, input int val, input int lo, input int hi);
        n_chk++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    // Monitor: every en/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (en || err)) begin
            if (en && err) check("en_err_both", {en, err}, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_event", {en, err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_kind", en, mon_e.is_wr);
                if (mon_e.is_wr) begin
                    check("wr_addr", addr, mon_e.a);
                    check("wr_data", data, mon_e.d);
                end
                check_win("event_latency", cyc - last_start, mon_e.lo, mon_e.hi);
            end
        end
        if (en) check("en_width", en_prev, 32'd0);
        en_prev <= en;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (100) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        if (!stop) bit_time(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d, 1'b1);
`ifdef CHECKSUM_EN
        send_byte(c, 1'b1);
`endif
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        sb.push_back('{1'b1, a, d, 940, 975});
    endtask

    task automatic push_err(input int lo, input int hi);
        sb.push_back('{1'b0, 3'd0, 8'd0, lo, hi});
    endtask

    task automatic check_held(input logic [2:0] a, input logic [7:0] d);
        check("held_addr", addr, a);
        check("held_data", data, d);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data", data, 32'd0);
        check("reset_addr", addr, 32'd0);
        check("reset_en", en, 32'd0);
        check("reset_err", err, 32'd0);
        rst = 1'b0;
        idle(20);

        // Good frame at the highest legal address.
        push_wr(3'd4, 8'h80);
        send_frame(8'h04, 8'h80, 8'h21);
        idle(300);

`ifdef CHECKSUM_EN
        // Bad checksum: err only, outputs unchanged.
        push_err(940, 975);
        send_frame(8'h04, 8'h80, 8'h22);
        idle(300);
        check_held(3'd4, 8'h80);
`endif

        // A lone non-sync byte in IDLE is ignored silently.
        send_byte(8'h3C, 1'b1);
        idle(300);

        // Address one past the limit, then address 0.
        push_err(940, 975);
        send_frame(8'h05, 8'h10, 8'hB0);
        idle(300);
        check_held(3'd4, 8'h80);
        push_wr(3'd0, 8'h10);
        send_frame(8'h00, 8'h10, 8'hB5);
        idle(300);

        // Stalled frame times out 40 bit periods after its last start bit.
        push_err(3990, 4030);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(4300);
        check_held(3'd0, 8'h10);
        push_wr(3'd2, 8'h07);
        send_frame(8'h02, 8'h07, 8'hA0);
        idle(300);

        // Framing error on the DATA byte, then a short low glitch on idle rx.
        push_err(940, 975);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h33, 1'b0);
        idle(500);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(1500);
        check_held(3'd2, 8'h07);

        // Reset in the middle of the DATA byte discards the frame.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        rx = 1'b0;
        repeat (250) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_data", data, 32'd0);
        check("rst_mid_addr", addr, 32'd0);
        check("rst_mid_en", en, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1500);

        // Maximum data value.
        push_wr(3'd1, 8'hFF);
        send_frame(8'h01, 8'hFF, 8'h5B);
        idle(300);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
